// File: rtl/branch_resolve_unit.sv
// Resolves conditional branches and jumps in EX, compares against the fetch-time prediction,
// and drives redirect/flush, predictor update strobes and saturating performance counters.
module branch_resolve_unit #(
   parameter int XLEN         = 32,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            valid_ex,
   input  logic            stall_ex,
   input  logic [31:0]     instr_ex,
   input  logic [XLEN-1:0] pc_ex,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   input  logic            jump_ex,
   input  logic [XLEN-1:0] jump_target,
   input  logic            pred_taken,
   input  logic [XLEN-1:0] pred_target,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            flush,
   output logic            upd_valid,
   output logic [XLEN-1:0] upd_pc,
   output logic [XLEN-1:0] upd_target,
   output logic            upd_taken,
   output logic            upd_is_branch,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);

   typedef enum logic {IDLE, FLUSH} state_t;

   state_t     state;
   logic [2:0] flush_cnt;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [12:0]     b_imm;
   logic [XLEN-1:0] br_target;
   logic            is_branch;
   logic            is_ctrl;
   logic            eq;
   logic            lt_s;
   logic            lt_u;
   logic            cond;
   logic            actual_taken;
   logic [XLEN-1:0] actual_target;
   logic            mispred;
   logic            resolve_en;
   logic            unused_bits;

   assign opcode = instr_ex[6:0];
   assign funct3 = instr_ex[14:12];
   assign b_imm  = {instr_ex[31], instr_ex[7], instr_ex[30:25], instr_ex[11:8], 1'b0};
   assign unused_bits = ^instr_ex[24:15];

   assign br_target = pc_ex + {{(XLEN-13){b_imm[12]}}, b_imm};

   // funct3 010/011 are not defined branch encodings and fall through as non-control.
   assign is_branch = (opcode == 7'b1100011) && (funct3 != 3'b010) && (funct3 != 3'b011);
   assign is_ctrl   = jump_ex | is_branch;

   assign eq   = (rs1_val == rs2_val);
   assign lt_s = ($signed(rs1_val) < $signed(rs2_val));
   assign lt_u = (rs1_val < rs2_val);

   always_comb begin
      cond = 1'b0;
      case (funct3)
         3'b000:  cond = eq;
         3'b001:  cond = !eq;
         3'b100:  cond = lt_s;
         3'b101:  cond = !lt_s;
         3'b110:  cond = lt_u;
         3'b111:  cond = !lt_u;
         default: cond = 1'b0;
      endcase
   end

   assign actual_taken  = jump_ex | (is_branch & cond);
   assign actual_target = jump_ex ? jump_target : br_target;
   assign mispred       = (actual_taken != pred_taken) |
                          (actual_taken & (pred_target != actual_target));
   assign resolve_en    = valid_ex & !stall_ex & (state == IDLE);

   // Strobes default low each cycle so redirect_valid/upd_valid are single-cycle pulses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         flush_cnt      <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         flush          <= 1'b0;
         upd_valid      <= 1'b0;
         upd_pc         <= '0;
         upd_target     <= '0;
         upd_taken      <= 1'b0;
         upd_is_branch  <= 1'b0;
         branch_cnt     <= '0;
         mispred_cnt    <= '0;
      end else begin
         redirect_valid <= 1'b0;
         upd_valid      <= 1'b0;
         case (state)
            IDLE: begin
               if (resolve_en) begin
                  if (is_ctrl) begin
                     upd_valid     <= 1'b1;
                     upd_pc        <= pc_ex;
                     upd_target    <= actual_target;
                     upd_taken     <= actual_taken;
                     upd_is_branch <= !jump_ex;
                     if (branch_cnt != '1)
                        branch_cnt <= branch_cnt + CNT_W'(1);
                  end
                  if (mispred) begin
                     redirect_valid <= 1'b1;
                     redirect_pc    <= actual_taken ? actual_target : (pc_ex + XLEN'(4));
                     flush          <= 1'b1;
                     flush_cnt      <= 3'(FLUSH_CYCLES - 1);
                     state          <= FLUSH;
                     if (mispred_cnt != '1)
                        mispred_cnt <= mispred_cnt + CNT_W'(1);
                  end
               end
            end
            FLUSH: begin
               // EX is ignored here; the counter runs regardless of stall_ex.
               if (flush_cnt == 3'd0) begin
                  state <= IDLE;
                  flush <= 1'b0;
               end else begin
                  flush_cnt <= flush_cnt - 3'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (FLUSH_CYCLES=2, CNT_W=4).
module tb_branch_resolve_unit;

   logic        clk;
   logic        rst_n;
   logic        valid_ex;
   logic        stall_ex;
   logic [31:0] instr_ex;
   logic [31:0] pc_ex;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic        jump_ex;
   logic [31:0] jump_target;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        flush;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic [31:0] upd_target;
   logic        upd_taken;
   logic        upd_is_branch;
   logic [3:0]  branch_cnt;
   logic [3:0]  mispred_cnt;

   int compared;
   int mismatched;

   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] ADDI = 32'h0010_0093;
   localparam logic [31:0] JAL  = 32'h0800_006F;

   branch_resolve_unit #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .valid_ex(valid_ex), .stall_ex(stall_ex),
      .instr_ex(instr_ex), .pc_ex(pc_ex), .rs1_val(rs1_val), .rs2_val(rs2_val),
      .jump_ex(jump_ex), .jump_target(jump_target), .pred_taken(pred_taken),
      .pred_target(pred_target), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .flush(flush), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
      .upd_taken(upd_taken), .upd_is_branch(upd_is_branch), .branch_cnt(branch_cnt),
      .mispred_cnt(mispred_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] make_b(input logic [2:0] f3, input logic [12:0] imm);
      return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction

   task automatic idleInputs();
      valid_ex    = 1'b0;
      stall_ex    = 1'b0;
      instr_ex    = NOP;
      pc_ex       = '0;
      rs1_val     = '0;
      rs2_val     = '0;
      jump_ex     = 1'b0;
      jump_target = '0;
      pred_taken  = 1'b0;
      pred_target = '0;
   endtask

   // Called at a negedge; returns at the following negedge with the registered result visible.
   task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic jmp, input logic [31:0] jt,
                                input logic pt, input logic [31:0] ptgt);
      valid_ex    = 1'b1;
      instr_ex    = instr;
      pc_ex       = pc;
      rs1_val     = a;
      rs2_val     = b;
      jump_ex     = jmp;
      jump_target = jt;
      pred_taken  = pt;
      pred_target = ptgt;
      @(negedge clk);
      idleInputs();
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      idleInputs();
      rst_n = 1'b0;
      waitCycles(3);
      checkOutput("reset_redirect", 32'(redirect_valid), 32'd0);
      checkOutput("reset_flush", 32'(flush), 32'd0);
      checkOutput("reset_upd_valid", 32'(upd_valid), 32'd0);
      checkOutput("reset_branch_cnt", 32'(branch_cnt), 32'd0);
      checkOutput("reset_mispred_cnt", 32'(mispred_cnt), 32'd0);

      // beq taken right after reset release, predicted not-taken
      rst_n = 1'b1;
      applyStimulus(make_b(3'b000, 13'd16), 32'h100, 32'd5, 32'd5, 1'b0, '0, 1'b0, '0);
      checkOutput("beq_redirect", 32'(redirect_valid), 32'd1);
      checkOutput("beq_redirect_pc", redirect_pc, 32'h110);
      checkOutput("beq_flush1", 32'(flush), 32'd1);
      checkOutput("beq_upd_valid", 32'(upd_valid), 32'd1);
      checkOutput("beq_upd_taken", 32'(upd_taken), 32'd1);
      checkOutput("beq_upd_is_branch", 32'(upd_is_branch), 32'd1);
      checkOutput("beq_upd_pc", upd_pc, 32'h100);
      checkOutput("beq_mispred_cnt", 32'(mispred_cnt), 32'd1);
      checkOutput("beq_branch_cnt", 32'(branch_cnt), 32'd1);
      waitCycles(1);
      checkOutput("beq_flush2", 32'(flush), 32'd1);
      checkOutput("beq_redirect_pulse", 32'(redirect_valid), 32'd0);
      checkOutput("beq_upd_pulse", 32'(upd_valid), 32'd0);
      waitCycles(1);
      checkOutput("beq_flush_end", 32'(flush), 32'd0);

      // blt signed: -1 < 1 taken, negative offset
      applyStimulus(make_b(3'b100, 13'h1FF8), 32'h300, 32'hFFFF_FFFF, 32'd1, 1'b0, '0, 1'b0, '0);
      checkOutput("blt_redirect", 32'(redirect_valid), 32'd1);
      checkOutput("blt_redirect_pc", redirect_pc, 32'h2F8);
      checkOutput("blt_mispred_cnt", 32'(mispred_cnt), 32'd2);
      waitCycles(2);
      checkOutput("blt_flush_end", 32'(flush), 32'd0);

      // bltu unsigned: 0xFFFFFFFF < 1 false, correctly predicted not-taken
      applyStimulus(make_b(3'b110, 13'd8), 32'h340, 32'hFFFF_FFFF, 32'd1, 1'b0, '0, 1'b0, '0);
      checkOutput("bltu_upd_valid", 32'(upd_valid), 32'd1);
      checkOutput("bltu_upd_taken", 32'(upd_taken), 32'd0);
      checkOutput("bltu_redirect", 32'(redirect_valid), 32'd0);
      checkOutput("bltu_flush", 32'(flush), 32'd0);
      checkOutput("bltu_branch_cnt", 32'(branch_cnt), 32'd3);
      checkOutput("bltu_mispred_cnt", 32'(mispred_cnt), 32'd2);

      // jal correctly predicted
      applyStimulus(JAL, 32'h400, '0, '0, 1'b1, 32'h480, 1'b1, 32'h480);
      checkOutput("jal_upd_valid", 32'(upd_valid), 32'd1);
      checkOutput("jal_upd_is_branch", 32'(upd_is_branch), 32'd0);
      checkOutput("jal_upd_target", upd_target, 32'h480);
      checkOutput("jal_redirect", 32'(redirect_valid), 32'd0);
      checkOutput("jal_branch_cnt", 32'(branch_cnt), 32'd4);

      // jump with wrong predicted target; instr is a not-taken bne to show jump priority
      applyStimulus(make_b(3'b001, 13'd64), 32'h400, 32'd7, 32'd7, 1'b1, 32'h480, 1'b1, 32'h500);
      checkOutput("jmp_bad_tgt_redirect", 32'(redirect_valid), 32'd1);
      checkOutput("jmp_bad_tgt_pc", redirect_pc, 32'h480);
      checkOutput("jmp_bad_tgt_is_branch", 32'(upd_is_branch), 32'd0);
      checkOutput("jmp_bad_tgt_mispred_cnt", 32'(mispred_cnt), 32'd3);
      waitCycles(2);

      // addi predicted taken
      applyStimulus(ADDI, 32'h200, '0, '0, 1'b0, '0, 1'b1, 32'h300);
      checkOutput("addi_redirect", 32'(redirect_valid), 32'd1);
      checkOutput("addi_redirect_pc", redirect_pc, 32'h204);
      checkOutput("addi_upd_valid", 32'(upd_valid), 32'd0);
      checkOutput("addi_branch_cnt", 32'(branch_cnt), 32'd5);
      checkOutput("addi_mispred_cnt", 32'(mispred_cnt), 32'd4);
      waitCycles(2);

      // mispredicting bne, then another mispredicting bne during FLUSH
      applyStimulus(make_b(3'b001, 13'h20), 32'h600, 32'd1, 32'd2, 1'b0, '0, 1'b0, '0);
      checkOutput("nest_first_redirect_pc", redirect_pc, 32'h620);
      applyStimulus(make_b(3'b001, 13'h40), 32'h700, 32'd3, 32'd4, 1'b0, '0, 1'b0, '0);
      checkOutput("nest_redirect", 32'(redirect_valid), 32'd0);
      checkOutput("nest_upd_valid", 32'(upd_valid), 32'd0);
      checkOutput("nest_flush", 32'(flush), 32'd1);
      checkOutput("nest_branch_cnt", 32'(branch_cnt), 32'd6);
      checkOutput("nest_mispred_cnt", 32'(mispred_cnt), 32'd5);
      waitCycles(1);
      checkOutput("nest_flush_end", 32'(flush), 32'd0);

      // stalled EX must not resolve
      stall_ex = 1'b1;
      applyStimulus(make_b(3'b000, 13'd16), 32'h800, 32'd1, 32'd1, 1'b0, '0, 1'b0, '0);
      checkOutput("stall_upd_valid", 32'(upd_valid), 32'd0);
      checkOutput("stall_redirect", 32'(redirect_valid), 32'd0);

      // counters clear on reset, then branch_cnt saturates at 15 after 16 branches
      rst_n = 1'b0;
      waitCycles(1);
      checkOutput("rst2_branch_cnt", 32'(branch_cnt), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++)
         applyStimulus(make_b(3'b001, 13'd8), 32'(32'h900 + 4 * i), 32'd9, 32'd9, 1'b0, '0, 1'b0, '0);
      checkOutput("sat_branch_cnt", 32'(branch_cnt), 32'd15);
      checkOutput("sat_mispred_cnt", 32'(mispred_cnt), 32'd0);

      // reset in the middle of FLUSH
      applyStimulus(make_b(3'b000, 13'd16), 32'hA00, 32'd1, 32'd1, 1'b0, '0, 1'b0, '0);
      checkOutput("midflush_flush", 32'(flush), 32'd1);
      rst_n = 1'b0;
      waitCycles(1);
      checkOutput("midflush_rst_flush", 32'(flush), 32'd0);
      checkOutput("midflush_rst_branch_cnt", 32'(branch_cnt), 32'd0);
      checkOutput("midflush_rst_mispred_cnt", 32'(mispred_cnt), 32'd0);
      checkOutput("midflush_rst_redirect", 32'(redirect_valid), 32'd0);
      rst_n = 1'b1;
      applyStimulus(make_b(3'b101, 13'd12), 32'hB00, 32'd4, 32'd4, 1'b0, '0, 1'b0, '0);
      checkOutput("post_rst_redirect", 32'(redirect_valid), 32'd1);
      checkOutput("post_rst_redirect_pc", redirect_pc, 32'hB0C);
      checkOutput("post_rst_mispred_cnt", 32'(mispred_cnt), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
